// File: rtl/irq_ctrl.sv
// irq_ctrl: 8-source latching/masking/prioritising interrupt controller; IRQ_CTRL_ROTATE_EN enables rotating priority
module irq_ctrl #(
    parameter int         NUM_SRC  = 8,
    parameter logic [7:0] MODE_RST = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] AD,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic       rw,
    input  logic       cs,
    input  logic [7:0] irq_in,
    output logic       irq
);
    localparam logic [8:0] IMPL_W = (9'd1 << NUM_SRC) - 9'd1;
    localparam logic [7:0] IMPL   = IMPL_W[7:0];
    logic [7:0] pending, mask, mode, prev, eligible, clr, pending_nxt;
    logic [2:0] ptr, idx, j;
    logic       act, wr_en, found;
    assign wr_en = cs & ~rw;
    assign clr = mode & (!wr_en ? 8'h00 : AD == 3'd0 ? DI : AD == 3'd3 ? 8'h01 << DI[2:0] : 8'h00);
    assign pending_nxt = IMPL & ((mode & ((pending & ~clr) | (irq_in & ~prev))) | (~mode & irq_in));
    assign eligible = pending & mask;
    assign act = |eligible;
    // first eligible source found scanning upward from ptr, wrapping modulo 8
    always_comb begin
        idx   = 3'd0;
        j     = 3'd0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            j = ptr + 3'(k);
            if (!found && eligible[j]) begin
                idx   = j;
                found = 1'b1;
            end
        end
    end
    // request latching, control registers and the registered CPU irq
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending <= 8'h00;
            mask    <= 8'h00;
            mode    <= MODE_RST;
            prev    <= 8'h00;
            irq     <= 1'b0;
        end else begin
            prev    <= irq_in;
            pending <= pending_nxt;
            irq     <= act;
            if (wr_en && AD == 3'd1) mask <= DI;
            if (wr_en && AD == 3'd2) mode <= DI;
        end
    end
`ifdef IRQ_CTRL_ROTATE_EN
    // any vector write moves the search start just past the acknowledged index
    always_ff @(posedge clk) begin
        if (!rst) ptr <= 3'd0;
        else if (wr_en && AD == 3'd3) ptr <= DI[2:0] + 3'd1;
    end
`else
    assign ptr = 3'd0;
`endif
    assign DO = AD == 3'd0 ? pending :
                AD == 3'd1 ? mask :
                AD == 3'd2 ? mode :
                AD == 3'd3 ? {act, 4'b0000, idx} :
                AD == 3'd4 ? {5'b00000, ptr} : 8'hFF;
endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller that arbitrates up to 8 peripheral interrupt sources onto the single CPU irq line.
- Sources include simpleio, uartio, gpio and spare lines.
- Sits in the DS7 window ($E6E0) on the CPU bus, with the same bus handshake as the other peripherals.
- Latches, masks and prioritises requests, presents the winning source index as a vector register, and clears on software acknowledge.

Parameters:
- NUM_SRC, 8, number of implemented sources (1..8). Unimplemented bits read 0 and never pend.
- MODE_RST, 8'h00, reset value of MODE register (1 = edge, 0 = level per source).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- AD  in  3  register address
- DI  in  8  write data from CPU
- DO  out  8  read data to CPU
- rw  in  1  1 = read, 0 = write
- cs  in  1  chip select (decode && vma)
- irq_in  in  8  source requests, active high, synchronous to clk
- irq  out  1  registered interrupt request to CPU

Behaviour:
- Register map:
  - 0 STATUS: R = pending[7:0]. W = write-1-to-clear, edge-mode bits only.
  - 1 MASK: R/W, 1 = enabled.
  - 2 MODE: R/W.
  - 3 VECTOR: R = {act, 4'b0, idx[2:0]}. W = ack, clears pending[DI[2:0]] if that source is edge mode.
  - 4 PTR: R = {5'b0, ptr}; writes ignored.
  - 5-7: read 8'hFF, writes ignored.
- Writes occur at the rising clk edge when cs=1 and rw=0. One bus cycle equals one write; no wait states.
- DO is combinational from AD and the current registers, independent of cs.
- Reset when rst=0 at a clock edge: pending=0, MASK=0, MODE=MODE_RST, prev=0, ptr=0, irq=0. DO then reflects the reset registers.
- prev register: prev <= irq_in every clock.
- Edge mode: pending[i] set at the edge where irq_in[i]=1 and prev[i]=0.
- Level mode: pending[i] <= irq_in[i] every edge. W1C and ack have no effect.
- Simultaneous set and clear (edge event plus W1C or ack on the same bit in the same cycle): set wins, bit stays 1.
- Writing MODE changes a bit's mode from the next edge. Switching edge->level reloads from irq_in. Switching level->edge keeps the current pending value.
- eligible = pending & MASK.
- act = |eligible.
- idx = highest-priority eligible index:
  - fixed priority: bit 0 highest.
  - rotating priority: see Optional Feature.
- irq <= act, registered.
- Latency: source edge sampled at edge k -> pending at k -> irq high at edge k+1. Ack or W1C at edge k -> irq low at edge k+1 if nothing else is eligible.
- Reading VECTOR has no side effects.
- Ack of a non-pending or level-mode index: no pending change; ptr still updates (rotate build only).
- Reset asserted mid-pending: all state cleared, irq low from the next edge. Sources still high after reset: edge-mode sources need a new 0->1 transition (prev reset to 0, so a held-high input re-pends one cycle after reset release); level-mode sources re-pend immediately.

Optional Feature:
- Macro IRQ_CTRL_ROTATE_EN.
- Defined:
  - 3-bit ptr; priority search starts at index ptr and wraps modulo 8.
  - Any VECTOR write sets ptr <= DI[2:0]+1 (mod 8; 7 wraps to 0).
  - PTR register reads ptr.
- Undefined:
  - fixed priority, bit 0 highest.
  - ptr constant 0; PTR reads 8'h00.

Test Plan:
- Reset with MODE_RST=8'h00 -> STATUS=00, MASK=00, MODE=00, VECTOR=00, irq=0; addr 6 reads FF.
- MASK=03, MODE=03, pulse irq_in[1] one cycle -> STATUS=02, irq high one cycle later, VECTOR=81; write VECTOR=01 -> STATUS=00, irq low next cycle.
- Level mode: MASK=10, hold irq_in[4]=1 -> VECTOR=84, W1C STATUS=10 ignored; drop irq_in[4] -> STATUS=00 next edge, irq=0 following edge.
- Fixed priority: MASK=FF, MODE=FF, pulse irq_in[5] and irq_in[2] together -> VECTOR=82; ack 2 -> VECTOR=85.
- Edge and W1C collision: irq_in[0] rises in the same cycle as a STATUS write of 01 with pending[0] already set -> STATUS bit0 remains 1.
- IRQ_CTRL_ROTATE_EN build: pending 01 and 80, ack 0 -> PTR=1, VECTOR=87; ack 7 -> PTR=0. Assert rst=0 mid-sequence -> PTR=0, STATUS=00, irq=0.
